imem_responder: RTL and testbench

//  Instruction-memory responder: the memory end of the fetch request/ack interface.
//  - Answers the fetch stage's fe_req/fe_addr with fe_ack/fe_data from a local word array.
//  - The array is filled through a load port (boot/testbench).
//  - Wait-state latency is programmable, so fetch stall and redirect paths can be exercised.

---
 rtl/imem_responder.sv | 186 ++++++++++++++++++
 tb/tb_imem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder
//  Description : Instruction-memory responder for the fetch request/ack
//                interface. Serves fe_req/fe_addr from a local word array
//                that is filled through a load port, with a programmable
//                number of wait states between request capture and fe_ack.
//                Optional feature macro: IMEM_FAULT_EN (adds fe_fault,
//                misalignment/range checking and write filtering).
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int unsigned LATENCY    = 0,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fe_req,
    input  logic [31:0] fe_addr,
    output logic        fe_ack,
    output logic [31:0] fe_data,
    input  logic        ld_wen,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
`ifdef IMEM_FAULT_EN
    ,
    output logic        fe_fault
`endif
);

    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [3:0]  C_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_WAIT    = 1'b1;

    // Word index of a byte address; upper bits and byte offset are dropped.
    function automatic logic [DEPTH_LOG2-1:0] idx_of(input logic [31:0] a);
        return a[DEPTH_LOG2+1:2];
    endfunction

`ifdef IMEM_FAULT_EN
    // Offset from BASE_ADDR wraps for addresses below the base, which pushes
    // it past the window, so a single unsigned test covers both ends.
    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (off >> (DEPTH_LOG2 + 2)) == 32'd0;
    endfunction

    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || !in_range(a);
    endfunction
`endif

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH];

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [31:0] req_addr_q;
    logic [31:0] req_addr_d;
    logic [31:0] hold_q;

    logic        ack_raw;
    logic        ack;
    logic [31:0] rd_addr;
    logic [31:0] rd_word;
    logic        rd_fault;
    logic [31:0] ack_word;
    logic        ld_ok;

    // ------------------------------------------------------------------
    // Request sequencing: same-cycle path or wait-state FSM
    // ------------------------------------------------------------------
    generate
        if (LATENCY == 0) begin : g_lat_zero
            // Combinational read: every cycle with fe_req high is acked.
            always_comb begin
                state_d    = ST_IDLE;
                cnt_d      = cnt_q;
                req_addr_d = req_addr_q;
                ack_raw    = fe_req;
                rd_addr    = fe_addr;
            end
        end else begin : g_lat_wait
            // Capture in IDLE, count down in WAIT; an address change restarts
            // the countdown in place, a dropped request aborts to IDLE.
            always_comb begin
                state_d    = state_q;
                cnt_d      = cnt_q;
                req_addr_d = req_addr_q;
                ack_raw    = 1'b0;
                rd_addr    = req_addr_q;
                case (state_q)
                    ST_IDLE: begin
                        if (fe_req) begin
                            req_addr_d = fe_addr;
                            cnt_d      = C_CNT_INIT;
                            state_d    = ST_WAIT;
                        end
                    end
                    default: begin
                        if (!fe_req) begin
                            state_d = ST_IDLE;
                        end else if (fe_addr != req_addr_q) begin
                            req_addr_d = fe_addr;
                            cnt_d      = C_CNT_INIT;
                            state_d    = ST_WAIT;
                        end else if (cnt_q != 4'd0) begin
                            cnt_d = cnt_q - 4'd1;
                        end else begin
                            ack_raw = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                endcase
            end
        end
    endgenerate

    // A cycle with reset asserted never completes a request.
    assign ack     = ack_raw & ~reset;
    assign rd_word = mem_q[idx_of(rd_addr)];

`ifdef IMEM_FAULT_EN
    assign rd_fault = is_fault(rd_addr);
    assign ld_ok    = in_range(ld_addr);
    assign fe_fault = ack & rd_fault;
`else
    assign rd_fault = 1'b0;
    assign ld_ok    = 1'b1;
`endif

    // Faulting requests never expose array contents.
    assign ack_word = rd_fault ? C_NOP : rd_word;

    assign fe_ack   = ack;
    assign fe_data  = ack ? ack_word : hold_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // FSM state, countdown and captured request address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            req_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Hold register keeps the last acked word on fe_data between acks.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= C_NOP;
        end else if (ack) begin
            hold_q <= ack_word;
        end
    end

    // Load-port write; a same-cycle read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (ld_wen && ld_ok) begin
            mem_q[idx_of(ld_addr)] <= ld_data;
        end
    end

    // Address bits outside the index window are intentionally ignored in
    // some configurations.
    logic w_unused;
    assign w_unused = ^{fe_addr, ld_addr, state_q};

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_responder
//  Description : Directed self-checking bench for imem_responder. Three
//                instances (LATENCY 0, 2, 3) share one stimulus stream;
//                each scenario checks the instance it targets.
//                Optional feature macro: IMEM_FAULT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fe_req;
    logic [31:0] fe_addr;
    logic        ld_wen;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic        ack0, ack2, ack3;
    logic [31:0] data0, data2, data3;
`ifdef IMEM_FAULT_EN
    logic        flt0, flt2, flt3;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_mem [8];

    always #5 clk = ~clk;

    imem_responder #(.LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset), .fe_req(fe_req), .fe_addr(fe_addr),
        .fe_ack(ack0), .fe_data(data0),
        .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_FAULT_EN
        , .fe_fault(flt0)
`endif
    );

    imem_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .fe_req(fe_req), .fe_addr(fe_addr),
        .fe_ack(ack2), .fe_data(data2),
        .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_FAULT_EN
        , .fe_fault(flt2)
`endif
    );

    imem_responder #(.LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .fe_req(fe_req), .fe_addr(fe_addr),
        .fe_ack(ack3), .fe_data(data3),
        .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_FAULT_EN
        , .fe_fault(flt3)
`endif
    );

    // Advance past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (mid-cycle).
    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        reset = 1'b1; fe_req = 1'b0; fe_addr = 32'd0;
        ld_wen = 1'b0; ld_addr = 32'd0; ld_data = 32'd0;
        cyc(); cyc();
        reset = 1'b0;
        settle();
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
        checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL reset_ack2 got=%b exp=0", ack2); end
        checks++; if (ack3 !== 1'b0) begin failures++; $display("FAIL reset_ack3 got=%b exp=0", ack3); end
        checks++; if (data0 !== NOP) begin failures++; $display("FAIL reset_data0 got=%h exp=%h", data0, NOP); end
        checks++; if (data2 !== NOP) begin failures++; $display("FAIL reset_data2 got=%h exp=%h", data2, NOP); end
        checks++; if (data3 !== NOP) begin failures++; $display("FAIL reset_data3 got=%h exp=%h", data3, NOP); end
        cyc();
    endtask

    task automatic test_load();
        for (int i = 0; i < 8; i++) begin
            ld_wen  = 1'b1;
            ld_addr = BASE + 32'(4 * i);
            ld_data = exp_mem[i];
            cyc();
        end
        ld_wen = 1'b0;
        cyc();
    endtask

    // Same-cycle ack, address aliasing and hold behaviour.
    task automatic test_lat0();
        fe_req = 1'b1; fe_addr = BASE;
        settle();
        checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL lat0_ack got=%b exp=1", ack0); end
        checks++; if (data0 !== exp_mem[0]) begin failures++; $display("FAIL lat0_data got=%h exp=%h", data0, exp_mem[0]); end
        cyc();
        fe_addr = 32'h0000_0014;
        settle();
        checks++; if (data0 !== exp_mem[5]) begin failures++; $display("FAIL lat0_alias got=%h exp=%h", data0, exp_mem[5]); end
        cyc();
        fe_req = 1'b0; fe_addr = BASE;
        settle();
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL lat0_noreq_ack got=%b exp=0", ack0); end
        checks++; if (data0 !== exp_mem[5]) begin failures++; $display("FAIL lat0_hold got=%h exp=%h", data0, exp_mem[5]); end
        checks++; if ({ack2, ack3} !== 2'b00) begin failures++; $display("FAIL noreq_ack23 got=%b exp=00", {ack2, ack3}); end
        cyc();
    endtask

    // Held request acked exactly LATENCY cycles after capture.
    task automatic test_latency();
        fe_req = 1'b1; fe_addr = BASE + 32'd4;
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++; if (ack2 !== (k == 2)) begin failures++; $display("FAIL lat2_ack k=%0d got=%b exp=%b", k, ack2, (k == 2)); end
            checks++; if (ack3 !== (k == 3)) begin failures++; $display("FAIL lat3_ack k=%0d got=%b exp=%b", k, ack3, (k == 3)); end
            if (k == 2) begin
                checks++; if (data2 !== exp_mem[1]) begin failures++; $display("FAIL lat2_data got=%h exp=%h", data2, exp_mem[1]); end
            end
            if (k == 3) begin
                checks++; if (data3 !== exp_mem[1]) begin failures++; $display("FAIL lat3_data got=%h exp=%h", data3, exp_mem[1]); end
            end
            cyc();
        end
        fe_req = 1'b0;
        cyc();
    endtask

    // Address change mid-wait restarts the countdown for the new address.
    task automatic test_redirect();
        fe_req = 1'b1; fe_addr = BASE + 32'd8;
        for (int k = 0; k < 5; k++) begin
            if (k >= 1) fe_addr = BASE + 32'd16;
            settle();
            checks++; if (ack3 !== (k == 4)) begin failures++; $display("FAIL redir3_ack k=%0d got=%b exp=%b", k, ack3, (k == 4)); end
            checks++; if (ack2 !== (k == 3)) begin failures++; $display("FAIL redir2_ack k=%0d got=%b exp=%b", k, ack2, (k == 3)); end
            if (k == 4) begin
                checks++; if (data3 !== exp_mem[4]) begin failures++; $display("FAIL redir3_data got=%h exp=%h", data3, exp_mem[4]); end
            end
            cyc();
        end
        fe_req = 1'b0;
        cyc();
    endtask

    // Dropped request: no ack, hold keeps last word, next request timed afresh.
    task automatic test_abort();
        fe_req = 1'b1; fe_addr = BASE + 32'd28;
        cyc(); cyc();
        settle();
        checks++; if (data2 !== exp_mem[7]) begin failures++; $display("FAIL abort_prior got=%h exp=%h", data2, exp_mem[7]); end
        cyc();
        fe_req = 1'b0;
        cyc();
        fe_req = 1'b1; fe_addr = BASE + 32'd12;
        settle();
        checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL abort_t0 got=%b exp=0", ack2); end
        cyc();
        fe_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL abort_ack k=%0d got=%b exp=0", k, ack2); end
            checks++; if (data2 !== exp_mem[7]) begin failures++; $display("FAIL abort_hold k=%0d got=%h exp=%h", k, data2, exp_mem[7]); end
            cyc();
        end
        fe_req = 1'b1; fe_addr = BASE + 32'd20;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (ack2 !== (k == 2)) begin failures++; $display("FAIL abort_next k=%0d got=%b exp=%b", k, ack2, (k == 2)); end
            if (k == 2) begin
                checks++; if (data2 !== exp_mem[5]) begin failures++; $display("FAIL abort_next_data got=%h exp=%h", data2, exp_mem[5]); end
            end
            cyc();
        end
        fe_req = 1'b0;
        cyc();
    endtask

    // Continuously held request: one ack per LATENCY+1 cycles.
    task automatic test_back_to_back();
        fe_req = 1'b1; fe_addr = BASE + 32'd8;
        for (int k = 0; k < 9; k++) begin
            settle();
            checks++; if (ack2 !== ((k % 3) == 2)) begin failures++; $display("FAIL b2b2_ack k=%0d got=%b exp=%b", k, ack2, ((k % 3) == 2)); end
            checks++; if (ack3 !== ((k % 4) == 3)) begin failures++; $display("FAIL b2b3_ack k=%0d got=%b exp=%b", k, ack3, ((k % 4) == 3)); end
            if ((k % 3) == 2) begin
                checks++; if (data2 !== exp_mem[2]) begin failures++; $display("FAIL b2b2_data k=%0d got=%h exp=%h", k, data2, exp_mem[2]); end
            end
            cyc();
        end
        fe_req = 1'b0;
        cyc();
    endtask

    // Read and write of the same word in one cycle returns the old word.
    task automatic test_load_collision();
        fe_req = 1'b1; fe_addr = BASE + 32'd24;
        ld_wen = 1'b1; ld_addr = BASE + 32'd24; ld_data = 32'hDEAD_BEEF;
        settle();
        checks++; if (data0 !== exp_mem[6]) begin failures++; $display("FAIL coll_old got=%h exp=%h", data0, exp_mem[6]); end
        cyc();
        exp_mem[6] = 32'hDEAD_BEEF;
        ld_wen = 1'b0;
        settle();
        checks++; if (data0 !== exp_mem[6]) begin failures++; $display("FAIL coll_new got=%h exp=%h", data0, exp_mem[6]); end
        cyc();
        fe_req = 1'b0;
        cyc();
    endtask

    // Reset during WAIT drops the request; a still-held request is recaptured.
    task automatic test_reset_mid_wait();
        fe_req = 1'b1; fe_addr = BASE;
        settle();
        checks++; if (data3 === NOP) begin failures++; $display("FAIL rst_pre_hold got=%h exp=!%h", data3, NOP); end
        cyc();
        reset = 1'b1;
        settle();
        checks++; if (ack3 !== 1'b0) begin failures++; $display("FAIL rst_during_ack got=%b exp=0", ack3); end
        cyc();
        reset = 1'b0;
        for (int k = 2; k < 6; k++) begin
            settle();
            checks++; if (ack3 !== (k == 5)) begin failures++; $display("FAIL rst_ack k=%0d got=%b exp=%b", k, ack3, (k == 5)); end
            if (k < 5) begin
                checks++; if (data3 !== NOP) begin failures++; $display("FAIL rst_data k=%0d got=%h exp=%h", k, data3, NOP); end
            end else begin
                checks++; if (data3 !== exp_mem[0]) begin failures++; $display("FAIL rst_reack_data got=%h exp=%h", data3, exp_mem[0]); end
            end
            cyc();
        end
        fe_req = 1'b0;
        cyc();
    endtask

`ifdef IMEM_FAULT_EN
    task automatic test_fault();
        logic [31:0] addrs [3];
        logic        flts  [3];
        addrs[0] = 32'h7FFF_FFFC; flts[0] = 1'b1;
        addrs[1] = 32'h8000_0002; flts[1] = 1'b1;
        addrs[2] = BASE;          flts[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fe_req = 1'b1; fe_addr = addrs[i];
            settle();
            checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL fault_ack i=%0d got=%b exp=1", i, ack0); end
            checks++; if (flt0 !== flts[i]) begin failures++; $display("FAIL fault_flag i=%0d got=%b exp=%b", i, flt0, flts[i]); end
            checks++; if (data0 !== (flts[i] ? NOP : exp_mem[0])) begin failures++; $display("FAIL fault_data i=%0d got=%h", i, data0); end
            cyc();
        end
        fe_req = 1'b0;
        ld_wen = 1'b1; ld_addr = BASE + 32'h0000_1000; ld_data = 32'h1234_5678;
        cyc();
        ld_wen = 1'b0; fe_req = 1'b1; fe_addr = BASE;
        settle();
        checks++; if (data0 !== exp_mem[0]) begin failures++; $display("FAIL fault_ldfilter got=%h exp=%h", data0, exp_mem[0]); end
        cyc();
        fe_req = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        exp_mem[0] = 32'h0050_0093;
        for (int i = 1; i < 8; i++) exp_mem[i] = 32'hC0DE_0000 + 32'(i * 32'h0101);
        test_reset();
        test_load();
        test_lat0();
        test_latency();
        test_redirect();
        test_abort();
        test_back_to_back();
        test_load_collision();
`ifdef IMEM_FAULT_EN
        test_fault();
`endif
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
